pseudo_lru_nway: RTL and testbench

Parametrised tree pseudo-LRU replacement controller for the set-associative caches: it holds WAYS-1 tree bits per set for SETS sets and applies hit/fill touches. On request it returns a registered victim way for a set, preferring invalid ways. It sits beside the tag/valid arrays in the cache datapath and is driven by the cache control FSM.

---
 rtl/lc3b_types.sv | 23 ++
 rtl/plru_tree_logic.sv | 49 ++++
 rtl/pseudo_lru_nway.sv | 110 +++++++++++
 tb/tb_pseudo_lru_nway.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared cache types: largest supported associativity, a tree-bits container
// sized for it, and a constant mask helper for one-hot to binary conversion.
package lc3b_types;

  localparam int plru_max_ways = 16;

  // Tree bits for the widest supported configuration (WAYS-1 internal nodes).
  typedef logic [plru_max_ways-2:0] plru_tree_t;

  // Mask of all way indices whose bit b is set; ANDed with a one-hot way
  // vector and OR-reduced it yields bit b of the encoded way index.
  function automatic logic [plru_max_ways-1:0] way_bit_mask(input int b);
    logic [plru_max_ways-1:0] m;
    m = '0;
    for (int i = 0; i < plru_max_ways; i++) begin
      if (((i >> b) & 1) != 0) begin
        m = m | ({{(plru_max_ways-1){1'b0}}, 1'b1} << i);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// Combinational tree pseudo-LRU logic for one set: walks the heap-numbered
// tree to the victim way and produces the tree bits after touching i_way.
module plru_tree_logic
  import lc3b_types::*;
#(
  parameter int WAYS = 16
) (
  input  logic [WAYS-2:0]         i_tree,
  input  logic [$clog2(WAYS)-1:0] i_way,
  output logic [$clog2(WAYS)-1:0] o_victim,
  output logic [WAYS-2:0]         o_tree_next
);

  localparam int WAY_W = $clog2(WAYS);

  // Victim walk: reach marks the single node per level on the victim path.
  // A node bit of 1 steers into its low child, 0 into its high child.
  for (genvar gl = 0; gl <= WAY_W; gl++) begin : g_lvl
    logic [(1<<gl)-1:0] reach;
    if (gl == 0) begin : g_root
      assign reach = 1'b1;
    end else begin : g_kids
      for (genvar gp = 0; gp < (1 << gl); gp++) begin : g_pos
        localparam int PARENT = (1 << (gl - 1)) - 1 + gp / 2;
        if ((gp % 2) == 0) begin : g_low
          assign reach[gp] = g_lvl[gl-1].reach[gp/2] & i_tree[PARENT];
        end else begin : g_high
          assign reach[gp] = g_lvl[gl-1].reach[gp/2] & ~i_tree[PARENT];
        end
      end
    end
  end

  // The leaf level is one-hot on the victim way; encode it bit by bit.
  for (genvar gb = 0; gb < WAY_W; gb++) begin : g_enc
    assign o_victim[gb] = |(g_lvl[WAY_W].reach & WAYS'(way_bit_mask(gb)));
  end

  // Touch: a node at level LVL, position POS lies on the path to i_way when
  // the top LVL bits of i_way equal POS; it then takes the next way bit so
  // it points away from the touched way. Other nodes keep their value.
  for (genvar gn = 0; gn < WAYS - 1; gn++) begin : g_node
    localparam int LVL = $clog2(gn + 2) - 1;
    localparam int POS = gn + 1 - (1 << LVL);
    assign o_tree_next[gn] = ((i_way >> (WAY_W - LVL)) == WAY_W'(POS))
                           ? i_way[WAY_W-1-LVL] : i_tree[gn];
  end

endmodule

// File: rtl/pseudo_lru_nway.sv
// Per-set tree pseudo-LRU replacement controller. Holds WAYS-1 tree bits per
// set, applies hit/fill touches and returns a registered victim per lookup,
// preferring the lowest invalid way. A touch to the looked-up set in the
// same cycle is forwarded into the victim walk.
module pseudo_lru_nway
  import lc3b_types::*;
#(
  parameter  int WAYS  = 16,
  parameter  int SETS  = 8,
  localparam int WAY_W = $clog2(WAYS),
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch,
  input  logic [IDX_W-1:0] touch_set,
  input  logic [WAY_W-1:0] touch_way,
  input  logic             lookup,
  input  logic [IDX_W-1:0] lookup_set,
  input  logic [WAYS-1:0]  valid_mask,
  output logic             victim_valid,
  output logic [WAY_W-1:0] victim_way
);

  logic [WAYS-2:0]  w_set_tree [SETS];
  logic [WAYS-2:0]  w_touch_cur;
  logic [WAYS-2:0]  w_upd_tree;
  logic [WAYS-2:0]  w_lkp_tree;
  logic [WAYS-2:0]  w_lkp_touch;
  logic [WAYS-2:0]  w_wr_tree;
  logic [WAY_W-1:0] w_upd_victim;
  logic [WAY_W-1:0] w_lkp_victim;
  logic [WAY_W-1:0] w_tree_victim;
  logic             w_same_set;
  logic             w_fwd;
  logic [WAYS-1:0]  w_inv;
  logic [WAYS-1:0]  w_inv_low;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_victim_next;
  logic             r_victim_valid;
  logic [WAY_W-1:0] r_victim_way;

  // Per-set tree registers; reset points every set at way 0.
  for (genvar gi = 0; gi < SETS; gi++) begin : g_set
    logic [WAYS-2:0] r_tree;
    // Reload all-ones on reset, otherwise take the update when this set is touched.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_tree <= '1;
      end else if (touch && (touch_set == IDX_W'(gi))) begin
        r_tree <= w_wr_tree;
      end
    end
    assign w_set_tree[gi] = r_tree;
  end

  assign w_touch_cur = w_set_tree[touch_set];
  assign w_same_set  = (touch_set == lookup_set);
  assign w_fwd       = touch && w_same_set;

  // Update path: tree of the touched set with the touch applied.
  plru_tree_logic #(.WAYS(WAYS)) u_update (
    .i_tree      (w_touch_cur),
    .i_way       (touch_way),
    .o_victim    (w_upd_victim),
    .o_tree_next (w_upd_tree)
  );

  // Lookup path walks post-touch bits when the same set is touched this cycle.
  assign w_lkp_tree = w_fwd ? w_upd_tree : w_set_tree[lookup_set];

  plru_tree_logic #(.WAYS(WAYS)) u_lookup (
    .i_tree      (w_lkp_tree),
    .i_way       (touch_way),
    .o_victim    (w_lkp_victim),
    .o_tree_next (w_lkp_touch)
  );

  // When the sets coincide both instances see the same set: with a touch the
  // lookup copy already carries it (re-touching is idempotent), without one
  // the update copy walks the stored bits directly.
  assign w_wr_tree     = w_fwd ? w_lkp_touch : w_upd_tree;
  assign w_tree_victim = (w_same_set && !touch) ? w_upd_victim : w_lkp_victim;

  // Invalid preference: isolate the lowest clear valid bit and encode it.
  assign w_inv     = ~valid_mask;
  assign w_inv_low = w_inv & (-w_inv);
  for (genvar gb = 0; gb < WAY_W; gb++) begin : g_inv_enc
    assign w_inv_way[gb] = |(w_inv_low & WAYS'(way_bit_mask(gb)));
  end

  assign w_victim_next = (|w_inv) ? w_inv_way : w_tree_victim;

  // Result registers: one-cycle valid pulse per lookup, way held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_victim_valid <= 1'b0;
      r_victim_way   <= '0;
    end else begin
      r_victim_valid <= lookup;
      if (lookup) begin
        r_victim_way <= w_victim_next;
      end
    end
  end

  assign victim_valid = r_victim_valid;
  assign victim_way   = r_victim_way;

endmodule

// File: tb/tb_pseudo_lru_nway.sv
// Self-checking bench for pseudo_lru_nway: a 16-way/8-set and a 4-way/2-set
// instance driven in lockstep, checked against a heap-walk reference model.
module tb_pseudo_lru_nway;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        touch;
  logic        lookup;
  logic [2:0]  touch_set;
  logic [3:0]  touch_way;
  logic [2:0]  lookup_set;
  logic [15:0] valid_mask;
  logic        victim_valid;
  logic [3:0]  victim_way;
  logic [0:0]  touch_set4;
  logic [1:0]  touch_way4;
  logic [0:0]  lookup_set4;
  logic [3:0]  valid_mask4;
  logic        victim_valid4;
  logic [1:0]  victim_way4;

  int n_checks = 0;
  int n_errors = 0;

  plru_tree_t m16 [8];
  plru_tree_t m4 [2];
  int exp16_valid, exp16_way, exp4_valid, exp4_way;

  always #5 clk = ~clk;

  pseudo_lru_nway #(.WAYS(16), .SETS(8)) dut (
    .clk(clk), .rst(rst), .touch(touch), .touch_set(touch_set),
    .touch_way(touch_way), .lookup(lookup), .lookup_set(lookup_set),
    .valid_mask(valid_mask), .victim_valid(victim_valid), .victim_way(victim_way)
  );

  pseudo_lru_nway #(.WAYS(4), .SETS(2)) dut4 (
    .clk(clk), .rst(rst), .touch(touch), .touch_set(touch_set4),
    .touch_way(touch_way4), .lookup(lookup), .lookup_set(lookup_set4),
    .valid_mask(valid_mask4), .victim_valid(victim_valid4), .victim_way(victim_way4)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: follow the root-to-leaf path of way w, pointing each node away.
  function automatic plru_tree_t m_touch(input plru_tree_t t, input int nw, input int w);
    plru_tree_t r;
    int lv, node, b;
    r = t;
    lv = $clog2(nw);
    node = 0;
    for (int l = 0; l < lv; l++) begin
      b = (w >> (lv - 1 - l)) & 1;
      r[node] = (b != 0);
      node = 2 * node + 1 + b;
    end
    return r;
  endfunction

  function automatic int m_walk(input plru_tree_t t, input int nw);
    int lv, node, way;
    lv = $clog2(nw);
    node = 0;
    way = 0;
    for (int l = 0; l < lv; l++) begin
      if (t[node]) begin
        way = way * 2;
        node = 2 * node + 1;
      end else begin
        way = way * 2 + 1;
        node = 2 * node + 2;
      end
    end
    return way;
  endfunction

  function automatic int m_pick(input plru_tree_t t, input int nw, input logic [15:0] vm);
    for (int i = 0; i < nw; i++) begin
      if (!vm[i]) return i;
    end
    return m_walk(t, nw);
  endfunction

  // One transaction: drive at negedge, update the model, check after the edge.
  task automatic cyc(input logic r, input logic t, input int ts, input int tw,
                     input logic lk, input int ls, input logic [15:0] vm,
                     input int want, input string tag);
    logic [15:0] vm4;
    vm4 = {12'hFFF, vm[3:0]};
    rst = r; touch = t; lookup = lk;
    touch_set = ts[2:0]; touch_way = tw[3:0]; lookup_set = ls[2:0]; valid_mask = vm;
    touch_set4 = ts[0:0]; touch_way4 = tw[1:0]; lookup_set4 = ls[0:0]; valid_mask4 = vm[3:0];
    if (r) begin
      for (int s = 0; s < 8; s++) m16[s] = '1;
      for (int s = 0; s < 2; s++) m4[s] = '1;
      exp16_valid = 0; exp16_way = 0; exp4_valid = 0; exp4_way = 0;
    end else begin
      if (t) begin
        m16[ts & 7] = m_touch(m16[ts & 7], 16, tw & 15);
        m4[ts & 1]  = m_touch(m4[ts & 1], 4, tw & 3);
      end
      exp16_valid = lk ? 1 : 0;
      exp4_valid  = lk ? 1 : 0;
      if (lk) begin
        exp16_way = m_pick(m16[ls & 7], 16, vm);
        exp4_way  = m_pick(m4[ls & 1], 4, vm4);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, ".valid16"}, int'(victim_valid), exp16_valid);
    check_eq({tag, ".way16"}, int'(victim_way), exp16_way);
    check_eq({tag, ".valid4"}, int'(victim_valid4), exp4_valid);
    check_eq({tag, ".way4"}, int'(victim_way4), exp4_way);
    if (want >= 0) check_eq({tag, ".direct"}, int'(victim_way), want);
    $display("txn %s rst=%0b touch=%0b tset=%0d tway=%0d lookup=%0b lset=%0d mask=%h -> v16=%0b w16=%0d v4=%0b w4=%0d",
             tag, r, t, ts, tw, lk, ls, vm, victim_valid, victim_way, victim_valid4, victim_way4);
  endtask

  initial begin
    logic r, t, lk;
    int ts, ls;
    logic [15:0] vm;
    rst = 1'b1; touch = 1'b0; lookup = 1'b0;
    touch_set = '0; touch_way = '0; lookup_set = '0; valid_mask = '1;
    touch_set4 = '0; touch_way4 = '0; lookup_set4 = '0; valid_mask4 = '1;
    @(negedge clk);

    cyc(1, 0, 0, 0, 0, 0, 16'hFFFF, -1, "reset");
    cyc(0, 0, 0, 0, 1, 0, 16'hFFFF,  0, "lk_s0");
    cyc(0, 1, 3, 0, 0, 0, 16'hFFFF, -1, "t_s3w0");
    cyc(0, 0, 0, 0, 1, 3, 16'hFFFF,  8, "lk_s3");
    cyc(0, 0, 0, 0, 1, 0, 16'hFFFF,  0, "lk_s0_iso");
    cyc(0, 0, 0, 0, 0, 0, 16'hFFFF, -1, "idle_hold");
    for (int w = 0; w < 16; w++) cyc(0, 1, 2, w, 0, 0, 16'hFFFF, -1, "t_s2_seq");
    cyc(0, 0, 0, 0, 1, 2, 16'hFFFF,  0, "lk_s2_all");
    cyc(0, 1, 2, 0, 0, 0, 16'hFFFF, -1, "t_s2w0");
    cyc(0, 0, 0, 0, 1, 2, 16'hFFFF,  8, "lk_s2_w0");
    cyc(0, 0, 0, 0, 1, 4, 16'hFFF7,  3, "inv_w3");
    cyc(0, 0, 0, 0, 1, 4, 16'h7FFF, 15, "inv_w15");
    cyc(1, 0, 0, 0, 0, 0, 16'hFFFF, -1, "reset2");
    cyc(0, 1, 5, 0, 1, 5, 16'hFFFF,  8, "fwd_s5");
    cyc(0, 1, 6, 0, 1, 7, 16'hFFFF,  0, "indep_s7");
    cyc(0, 1, 1, 5, 0, 0, 16'hFFFF, -1, "t_s1w5");
    cyc(0, 0, 0, 0, 1, 1, 16'hFFFF, -1, "lk_pre_rst");
    cyc(1, 0, 0, 0, 1, 1, 16'hFFFF, -1, "rst_with_lk");
    cyc(0, 0, 0, 0, 1, 1, 16'hFFFF,  0, "lk_s1_post");
    for (int w = 0; w < 3; w++) cyc(0, 1, 1, w, 0, 0, 16'hFFFF, -1, "t_s1_small");
    cyc(0, 0, 0, 0, 1, 1, 16'hFFFF, -1, "lk_s1_small");
    cyc(0, 1, 1, 3, 0, 0, 16'hFFFF, -1, "t_s1w3");
    cyc(0, 0, 0, 0, 1, 1, 16'hFFFF, -1, "lk_s1_small2");
    cyc(0, 1, 1, 3, 1, 1, 16'hFFFF, -1, "t_idem");

    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      t  = ($urandom_range(0, 1) == 1);
      lk = ($urandom_range(0, 2) != 0);
      ts = $urandom_range(0, 7);
      ls = ($urandom_range(0, 3) == 0) ? ts : $urandom_range(0, 7);
      vm = ($urandom_range(0, 3) == 0) ? (16'($urandom) | 16'($urandom)) : 16'hFFFF;
      cyc(r, t, ts, $urandom_range(0, 15), lk, ls, vm, -1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
